tx_iq_sched: RTL and testbench

//  Owns the write side and read gating of the single-clock TX I/Q FIFO ahead of the DAC interface.

---
 rtl/tx_iq_sched_pkg.sv | 22 ++
 rtl/tx_iq_sched_if.sv | 22 ++
 rtl/tx_iq_gap_timer.sv | 29 ++
 rtl/tx_iq_sched.sv | 159 +++++++++++++++
 tb/tb_tx_iq_sched.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_iq_sched_pkg.sv
// Shared definitions for the TX I/Q FIFO scheduler: state encoding and a
// small helper that says which states open the read side of the FIFO.
package tx_iq_sched_pkg;

    localparam int STATE_W = 3;

    // Encoding is visible to software through sched_state, so values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_CORE_TX    = 3'd1,
        ST_CORE_DRAIN = 3'd2,
        ST_ARB_LOAD   = 3'd3,
        ST_ARB_PLAY   = 3'd4,
        ST_GAP        = 3'd5
    } sched_state_e;

    // Downstream may only pull samples while the scheduler is streaming or draining.
    function automatic logic state_plays(sched_state_e s);
        return (s == ST_CORE_TX) || (s == ST_CORE_DRAIN) || (s == ST_ARB_PLAY);
    endfunction

endpackage

// File: rtl/tx_iq_sched_if.sv
// Write/status bundle between the scheduler (master) and the TX I/Q FIFO (slave).
interface tx_iq_sched_if #(
    parameter int IQ_DATA_WIDTH  = 16,
    parameter int FIFO_CNT_WIDTH = 10
);
    logic [2*IQ_DATA_WIDTH-1:0] fifo_din;
    logic                       fifo_wren;
    logic                       fifo_flush;
    logic [FIFO_CNT_WIDTH-1:0]  fifo_data_count;
    logic                       fifo_full;
    logic                       fifo_empty;

    modport master (
        output fifo_din, fifo_wren, fifo_flush,
        input  fifo_data_count, fifo_full, fifo_empty
    );

    modport slave (
        input  fifo_din, fifo_wren, fifo_flush,
        output fifo_data_count, fifo_full, fifo_empty
    );
endinterface

// File: rtl/tx_iq_gap_timer.sv
// Inter-frame gap timer: loads a length, counts down, and flags the last gap cycle.
// A length of N yields max(N,1) gap cycles, so a zero length still gives one idle cycle.
module tx_iq_gap_timer #(
    parameter int GAP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [GAP_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 expire
);
    logic [GAP_WIDTH-1:0] count_reg;

    // Load on gap entry, then count down and saturate at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - GAP_WIDTH'(1);
        end
    end

    // The cycle that would decrement to zero is the final gap cycle.
    assign expire = (count_reg <= GAP_WIDTH'(1));

endmodule

// File: rtl/tx_iq_sched.sv
// TX I/Q FIFO scheduler: arbitrates the FIFO write side between the tx core
// stream and ARM-loaded arbitrary I/Q, gates the read side, inserts the
// inter-frame gap, generates core back-pressure and flags dropped writes.
module tx_iq_sched
    import tx_iq_sched_pkg::*;
#(
    parameter int IQ_DATA_WIDTH  = 16,
    parameter int FIFO_CNT_WIDTH = 10,
    parameter int GAP_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       core_tx_req,
    output logic                       core_grant,
    input  logic [2*IQ_DATA_WIDTH-1:0] core_iq,
    input  logic                       core_iq_valid,
    input  logic                       core_iq_last,
    output logic                       core_hold,
    input  logic [FIFO_CNT_WIDTH-1:0]  tx_hold_threshold,
    input  logic                       arb_mode,
    input  logic [2*IQ_DATA_WIDTH-1:0] arb_iq_in,
    input  logic                       arb_iq_wren,
    input  logic                       arb_trigger,
    input  logic [GAP_WIDTH-1:0]       gap_len,
    tx_iq_sched_if.master              fifo,
    output logic                       play_en,
    output logic                       arb_done,
    output logic                       ovf_err,
    input  logic                       err_clr,
    output logic [STATE_W-1:0]         sched_state
);
    sched_state_e state_reg, state_next;

    logic                       trig_reg;
    logic                       trig_rise;
    logic                       gap_load;
    logic                       gap_expire;

    logic                       core_grant_reg;
    logic                       core_hold_reg;
    logic [2*IQ_DATA_WIDTH-1:0] din_reg, din_next;
    logic                       wren_reg, wren_next;
    logic                       flush_reg;
    logic                       arb_done_reg;
    logic                       ovf_reg;
    logic                       wr_req;
    logic                       ovf_set;

    assign trig_rise = arb_trigger & ~trig_reg;

    tx_iq_gap_timer #(.GAP_WIDTH(GAP_WIDTH)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_len),
        .dec      (state_reg == ST_GAP),
        .expire   (gap_expire)
    );

    // Next-state decode; also decides when the gap timer is (re)loaded.
    always_comb begin
        state_next = state_reg;
        gap_load   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // ARM playback takes priority over a pending core request.
                if (arb_mode)
                    state_next = ST_ARB_LOAD;
                else if (core_tx_req && fifo.fifo_empty)
                    state_next = ST_CORE_TX;
            end
            ST_CORE_TX: begin
                if (core_iq_valid && core_iq_last)
                    state_next = ST_CORE_DRAIN;
            end
            ST_CORE_DRAIN: begin
                // The last sample's write is still in flight on the first drain
                // cycle, so empty is not trusted until that write has landed.
                if (fifo.fifo_empty && !wren_reg)
                    state_next = ST_GAP;
            end
            ST_ARB_LOAD: begin
                if (!arb_mode)
                    state_next = ST_IDLE;
                else if (trig_rise && !fifo.fifo_empty)
                    state_next = ST_ARB_PLAY;
            end
            ST_ARB_PLAY: begin
                // Leaving arbitrary mode mid-play is deferred until the buffer drains.
                if (fifo.fifo_empty)
                    state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_expire)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        gap_load = (state_next == ST_GAP) && (state_reg != ST_GAP);
    end

    // Write-source selection, full gating and drop detection.
    always_comb begin
        wr_req   = 1'b0;
        din_next = din_reg;
        case (state_reg)
            ST_CORE_TX: begin
                wr_req   = core_iq_valid;
                din_next = core_iq;
            end
            ST_ARB_LOAD: begin
                wr_req   = arb_iq_wren;
                din_next = arb_iq_in;
            end
            default: ;
        endcase
        wren_next = wr_req & ~fifo.fifo_full;
        // A write during playback can never be stored, so it counts as a drop.
        ovf_set   = (wr_req & fifo.fifo_full) |
                    ((state_reg == ST_ARB_PLAY) & arb_iq_wren);
    end

    // State, edge detector and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            trig_reg       <= 1'b0;
            core_grant_reg <= 1'b0;
            core_hold_reg  <= 1'b1;
            din_reg        <= '0;
            wren_reg       <= 1'b0;
            flush_reg      <= 1'b0;
            arb_done_reg   <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            trig_reg       <= arb_trigger;
            core_grant_reg <= (state_reg == ST_IDLE) && (state_next == ST_CORE_TX);
            core_hold_reg  <= (state_next != ST_CORE_TX) ||
                              (fifo.fifo_data_count > tx_hold_threshold);
            din_reg        <= din_next;
            wren_reg       <= wren_next;
            flush_reg      <= (state_reg == ST_ARB_LOAD) && !arb_mode;
            arb_done_reg   <= (state_reg == ST_ARB_PLAY) && (state_next == ST_GAP);
            ovf_reg        <= ovf_set | (ovf_reg & ~err_clr);
        end
    end

    assign core_grant      = core_grant_reg;
    assign core_hold       = core_hold_reg;
    assign fifo.fifo_din   = din_reg;
    assign fifo.fifo_wren  = wren_reg;
    assign fifo.fifo_flush = flush_reg;
    assign play_en         = state_plays(state_reg);
    assign arb_done        = arb_done_reg;
    assign ovf_err         = ovf_reg;
    assign sched_state     = state_reg;

endmodule

// File: tb/tb_tx_iq_sched.sv
// Bench for tx_iq_sched: count-only FIFO model, write-data scoreboard,
// an IDLE decision table and hand-written sequences for the multi-cycle cases.
module tb_tx_iq_sched;
    import tx_iq_sched_pkg::*;

    localparam int W     = 16;
    localparam int CW    = 10;
    localparam int GW    = 16;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            core_tx_req, core_grant, core_iq_valid, core_iq_last, core_hold;
    logic [2*W-1:0]  core_iq, arb_iq_in;
    logic [CW-1:0]   tx_hold_threshold;
    logic            arb_mode, arb_iq_wren, arb_trigger;
    logic [GW-1:0]   gap_len;
    logic            play_en, arb_done, ovf_err, err_clr;
    logic [2:0]      sched_state;

    tx_iq_sched_if #(.IQ_DATA_WIDTH(W), .FIFO_CNT_WIDTH(CW)) fif ();

    tx_iq_sched #(.IQ_DATA_WIDTH(W), .FIFO_CNT_WIDTH(CW), .GAP_WIDTH(GW)) dut (
        .clk               (clk),
        .rst               (rst),
        .core_tx_req       (core_tx_req),
        .core_grant        (core_grant),
        .core_iq           (core_iq),
        .core_iq_valid     (core_iq_valid),
        .core_iq_last      (core_iq_last),
        .core_hold         (core_hold),
        .tx_hold_threshold (tx_hold_threshold),
        .arb_mode          (arb_mode),
        .arb_iq_in         (arb_iq_in),
        .arb_iq_wren       (arb_iq_wren),
        .arb_trigger       (arb_trigger),
        .gap_len           (gap_len),
        .fifo              (fif.master),
        .play_en           (play_en),
        .arb_done          (arb_done),
        .ovf_err           (ovf_err),
        .err_clr           (err_clr),
        .sched_state       (sched_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // FIFO occupancy model: one cycle from wren to count, reads while play_en.
    int   fifo_cnt;
    logic rd_stall, force_ne, fifo_rd;
    assign fifo_rd              = play_en && !rd_stall && (fifo_cnt > 0);
    assign fif.fifo_data_count  = CW'(fifo_cnt);
    assign fif.fifo_full        = (fifo_cnt >= DEPTH);
    assign fif.fifo_empty       = (fifo_cnt == 0) && !force_ne;

    always @(posedge clk) begin
        if (rst || fif.fifo_flush)
            fifo_cnt <= 0;
        else
            fifo_cnt <= fifo_cnt + ((fif.fifo_wren && fifo_cnt < DEPTH) ? 1 : 0) - (fifo_rd ? 1 : 0);
    end

    // Scoreboard: every FIFO write must match the oldest expected sample.
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] sb_exp;
    int             wr_seen = 0;
    always @(negedge clk) begin
        if (fif.fifo_wren === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_wren", 1, 0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("fifo_din", fif.fifo_din, sb_exp);
                $display("write 0x%08h expected 0x%08h", fif.fifo_din, sb_exp);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        core_tx_req = 0; core_iq = '0; core_iq_valid = 0; core_iq_last = 0;
        arb_mode = 0; arb_iq_in = '0; arb_iq_wren = 0; arb_trigger = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        tick();
        rst = 1; tick(); tick(); rst = 0;
        exp_q.delete();
        force_ne = 0; rd_stall = 0;
    endtask

    task automatic core_send(input logic [2*W-1:0] d, input logic is_last);
        core_iq = d; core_iq_valid = 1; core_iq_last = is_last;
        exp_q.push_back(d);
        tick();
    endtask

    task automatic arb_send(input logic [2*W-1:0] d);
        arb_iq_in = d; arb_iq_wren = 1;
        exp_q.push_back(d);
        tick();
    endtask

    typedef struct {
        logic       mode;
        logic       req;
        logic       ne;
        logic [2:0] exp_state;
        logic       exp_grant;
        logic       exp_hold;
    } vec_t;
    vec_t vecs[6];

    int guard, gap_cycles, done_cnt, wr_base, max_cnt;
    logic hold_checked, over_prev;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1};
        tx_hold_threshold = 10'd400; gap_len = 16'd5;
        force_ne = 0; rd_stall = 0;

        // Reset values
        do_reset();
        check("rst_state",    sched_state, 0);
        check("rst_hold",     core_hold, 1);
        check("rst_grant",    core_grant, 0);
        check("rst_wren",     fif.fifo_wren, 0);
        check("rst_flush",    fif.fifo_flush, 0);
        check("rst_play_en",  play_en, 0);
        check("rst_arb_done", arb_done, 0);
        check("rst_ovf",      ovf_err, 0);
        check("rst_din",      fif.fifo_din, 0);

        // IDLE decision table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            arb_mode = vecs[i].mode; core_tx_req = vecs[i].req; force_ne = vecs[i].ne;
            tick();
            check($sformatf("vec%0d_state", i), sched_state, vecs[i].exp_state);
            check($sformatf("vec%0d_grant", i), core_grant,  vecs[i].exp_grant);
            check($sformatf("vec%0d_hold", i),  core_hold,   vecs[i].exp_hold);
            $display("vec %0d mode=%0b req=%0b ne=%0b -> state=%0d grant=%0b hold=%0b",
                     i, vecs[i].mode, vecs[i].req, vecs[i].ne, sched_state, core_grant, core_hold);
        end

        // Core packet: 20 samples, drain, 5-cycle gap, back to IDLE
        do_reset();
        tx_hold_threshold = 10'd400; gap_len = 16'd5;
        core_tx_req = 1; tick(); core_tx_req = 0;
        check("pkt_grant", core_grant, 1);
        check("pkt_state_tx", sched_state, 1);
        wr_base = wr_seen;
        for (int i = 0; i < 20; i++) begin
            core_send({W'(i + 100), W'(i)}, i == 19);
            if (i == 0) check("pkt_grant_pulse", core_grant, 0);
        end
        core_iq_valid = 0; core_iq_last = 0;
        check("pkt_state_drain", sched_state, 2);
        check("pkt_play_en_drain", play_en, 1);
        guard = 0;
        while (sched_state != 3'd5 && guard < 50) begin tick(); guard++; end
        check("pkt_reach_gap", sched_state, 5);
        check("pkt_gap_play_en", play_en, 0);
        gap_cycles = 0;
        while (sched_state == 3'd5 && gap_cycles < 100) begin tick(); gap_cycles++; end
        check("pkt_gap_cycles", gap_cycles, 5);
        check("pkt_back_idle", sched_state, 0);
        check("pkt_wren_count", wr_seen - wr_base, 20);

        // Zero-length gap still gives one gap cycle
        do_reset();
        gap_len = 16'd0;
        core_tx_req = 1; tick(); core_tx_req = 0;
        core_send(32'hA5A5_0001, 1'b1);
        core_iq_valid = 0; core_iq_last = 0;
        guard = 0;
        while (sched_state != 3'd5 && guard < 50) begin tick(); guard++; end
        gap_cycles = 0;
        while (sched_state == 3'd5 && gap_cycles < 100) begin tick(); gap_cycles++; end
        check("gap0_cycles", gap_cycles, 1);

        // Back-pressure: threshold 8, reads stalled, core obeys hold
        do_reset();
        tx_hold_threshold = 10'd8; rd_stall = 1;
        core_tx_req = 1; tick(); core_tx_req = 0;
        check("hold_low_at_grant", core_hold, 0);
        hold_checked = 0; over_prev = 0; max_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!core_hold) begin
                core_iq = {W'(c), W'(c + 7)}; core_iq_valid = 1;
                exp_q.push_back(core_iq);
            end else begin
                core_iq_valid = 0;
            end
            tick();
            if (over_prev && !hold_checked) begin
                check("hold_after_cnt9", core_hold, 1);
                hold_checked = 1;
            end
            over_prev = (fifo_cnt > 8);
            if (fifo_cnt > max_cnt) max_cnt = fifo_cnt;
        end
        core_iq_valid = 0;
        check("hold_threshold_reached", hold_checked, 1);
        check("hold_stays_high", core_hold, 1);
        check("hold_max_count_ok", max_cnt <= 12, 1);
        check("hold_no_ovf", ovf_err, 0);

        // Reset mid CORE_TX after 10 samples
        do_reset();
        tx_hold_threshold = 10'd400; rd_stall = 1;
        core_tx_req = 1; tick(); core_tx_req = 0;
        for (int i = 0; i < 10; i++) core_send({W'(i), W'(~i)}, 1'b0);
        rst = 1; core_iq = 32'hDEAD_BEEF; core_iq_valid = 1;
        tick();
        check("midrst_state", sched_state, 0);
        check("midrst_hold", core_hold, 1);
        check("midrst_wren", fif.fifo_wren, 0);
        check("midrst_play_en", play_en, 0);
        check("midrst_flush", fif.fifo_flush, 0);
        rst = 0; core_iq_valid = 0;
        check("midrst_sb_empty", exp_q.size(), 0);

        // Arbitrary: empty-FIFO trigger ignored, load 64, play, done, no replay, flush
        do_reset();
        gap_len = 16'd3;
        arb_mode = 1; tick();
        check("arb_enter_load", sched_state, 3);
        arb_trigger = 1; tick(); tick();
        check("trig_empty_state", sched_state, 3);
        check("trig_empty_play_en", play_en, 0);
        arb_trigger = 0;
        for (int i = 0; i < 64; i++) arb_send($urandom);
        arb_iq_wren = 0; tick(); tick();
        check("arb_no_play_while_load", play_en, 0);
        arb_trigger = 1; tick();
        check("arb_play_state", sched_state, 4);
        check("arb_play_en", play_en, 1);
        done_cnt = 0; guard = 0;
        while (sched_state == 3'd4 && guard < 300) begin
            tick(); guard++;
            if (arb_done) done_cnt++;
        end
        check("arb_reach_gap", sched_state, 5);
        check("arb_done_pulse", arb_done, 1);
        tick();
        check("arb_done_one_cycle", arb_done, 0);
        guard = 0;
        while (sched_state != 3'd3 && guard < 50) begin
            tick(); guard++;
            if (arb_done) done_cnt++;
        end
        check("arb_reload", sched_state, 3);
        arb_send(32'h1234_5678);
        arb_iq_wren = 0;
        for (int i = 0; i < 5; i++) tick();
        check("arb_no_replay", sched_state, 3);
        check("arb_done_count", done_cnt, 1);
        arb_mode = 0; tick();
        check("arb_exit_idle", sched_state, 0);
        check("arb_flush_pulse", fif.fifo_flush, 1);
        tick();
        check("arb_flush_one_cycle", fif.fifo_flush, 0);
        arb_trigger = 0;

        // Overflow: fill to full, one more write dropped, set beats clear
        do_reset();
        arb_mode = 1; tick();
        for (int i = 0; i < DEPTH; i++) arb_send({W'(i), W'(i ^ 16'h5A5A)});
        arb_iq_wren = 0; tick(); tick();
        check("ovf_before_full", ovf_err, 0);
        arb_iq_in = 32'hFFFF_0000; arb_iq_wren = 1; tick();
        check("ovf_drop_no_wren", fif.fifo_wren, 0);
        check("ovf_set", ovf_err, 1);
        err_clr = 1; tick();
        check("ovf_set_wins_clr", ovf_err, 1);
        arb_iq_wren = 0; tick();
        check("ovf_cleared", ovf_err, 0);
        err_clr = 0;
        arb_trigger = 1; tick();
        check("ovf_play_state", sched_state, 4);
        arb_iq_wren = 1; tick();
        check("play_write_no_wren", fif.fifo_wren, 0);
        check("play_write_ovf", ovf_err, 1);
        arb_iq_wren = 0;

        do_reset();
        check("sb_empty_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
